// File: rtl/flash_arbiter_pkg.sv
// Shared bus widths, arbiter state encoding and the round-robin helper
// for the flash_arbiter that sits in front of the flash wrapper.
package flash_arbiter_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [15:0] ARB_DEFAULT_TIMEOUT = 16'd4095;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY0   = 2'd1,
    ARB_BUSY1   = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  // On a tie the requester not served last wins; otherwise the lone requester.
  function automatic owner_e pick_owner(input logic sel0, input logic sel1,
                                        input owner_e last);
    owner_e win;
    if (sel0 && sel1) begin
      if (last == OWNER_M1) win = OWNER_M0;
      else                  win = OWNER_M1;
    end else if (sel1) begin
      win = OWNER_M1;
    end else begin
      win = OWNER_M0;
    end
    return win;
  endfunction

endpackage

// File: rtl/flash_arbiter.sv
// Two-master arbiter in front of the flash wrapper slave port: serialises
// transactions, routes ack/data to the owner, forces a release gap, times out.
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [WB_ADDR_W-1:0] m0_addr_i,
  input  logic [WB_DATA_W-1:0] m0_data_i,
  output logic [WB_DATA_W-1:0] m0_data_o,
  input  logic                 m0_select_i,
  input  logic                 m0_we_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,

  input  logic [WB_ADDR_W-1:0] m1_addr_i,
  input  logic [WB_DATA_W-1:0] m1_data_i,
  output logic [WB_DATA_W-1:0] m1_data_o,
  input  logic                 m1_select_i,
  input  logic                 m1_we_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,

  output logic [WB_ADDR_W-1:0] s_addr_o,
  output logic [WB_DATA_W-1:0] s_data_o,
  input  logic [WB_DATA_W-1:0] s_data_i,
  output logic                 s_select_o,
  output logic                 s_we_o,
  input  logic                 s_ack_i,

  output logic [1:0]           grant_o
);

  arb_state_e  state;
  arb_state_e  state_nxt;
  owner_e      last_grant;
  logic [15:0] tmo_cnt;
  logic        busy;
  logic        tmo_hit;

  assign busy    = (state == ARB_BUSY0) || (state == ARB_BUSY1);
  assign tmo_hit = (TIMEOUT_CYCLES != 16'd0) &&
                   (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= OWNER_M1;
      tmo_cnt    <= '0;
    end else begin
      state <= state_nxt;

      if (state == ARB_IDLE && state_nxt == ARB_BUSY0) last_grant <= OWNER_M0;
      if (state == ARB_IDLE && state_nxt == ARB_BUSY1) last_grant <= OWNER_M1;

      // Counter is zero on the first BUSY cycle because it is cleared outside BUSY.
      if (!busy) begin
        tmo_cnt <= '0;
      end else if (TIMEOUT_CYCLES != 16'd0 && tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    s_addr_o   = '0;
    s_data_o   = '0;
    s_select_o = 1'b0;
    s_we_o     = 1'b0;
    grant_o    = 2'b00;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_data_o  = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_data_o  = '0;

    case (state)
      ARB_IDLE: begin
        if (m0_select_i || m1_select_i) begin
          if (pick_owner(m0_select_i, m1_select_i, last_grant) == OWNER_M0)
            state_nxt = ARB_BUSY0;
          else
            state_nxt = ARB_BUSY1;
        end
      end

      ARB_BUSY0: begin
        grant_o    = 2'b01;
        s_addr_o   = m0_addr_i;
        s_data_o   = m0_data_i;
        s_select_o = m0_select_i;
        s_we_o     = m0_we_i;
        m0_ack_o   = s_ack_i;
        m0_data_o  = s_data_i;
        // An ack in the timeout cycle wins; a dropped select is a silent abort.
        m0_err_o   = tmo_hit && !s_ack_i && m0_select_i;
        if (s_ack_i || !m0_select_i || tmo_hit) state_nxt = ARB_RELEASE;
      end

      ARB_BUSY1: begin
        grant_o    = 2'b10;
        s_addr_o   = m1_addr_i;
        s_data_o   = m1_data_i;
        s_select_o = m1_select_i;
        s_we_o     = m1_we_i;
        m1_ack_o   = s_ack_i;
        m1_data_o  = s_data_i;
        m1_err_o   = tmo_hit && !s_ack_i && m1_select_i;
        if (s_ack_i || !m1_select_i || tmo_hit) state_nxt = ARB_RELEASE;
      end

      ARB_RELEASE: begin
        state_nxt = ARB_IDLE;
      end

      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios with literal expectations, then
// randomized masters/flash checked every cycle against a transaction-level model.
module tb_flash_arbiter;
  import flash_arbiter_pkg::*;

  localparam int AW  = WB_ADDR_W;
  localparam int DW  = WB_DATA_W;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          m0_select_i, m1_select_i;
  logic          m0_we_i, m1_we_i;
  logic          m0_ack_o, m1_ack_o;
  logic          m0_err_o, m1_err_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [DW-1:0] s_data_i;
  logic          s_select_o, s_we_o, s_ack_i;
  logic [1:0]    grant_o;

  flash_arbiter #(.TIMEOUT_CYCLES(16'(TMO))) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_select_i(m0_select_i), .m0_we_i(m0_we_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_select_i(m1_select_i), .m1_we_i(m1_we_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_select_o(s_select_o), .s_we_o(s_we_o), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_model = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 nobody, 0/1 a master, 2 the release gap),
  // who was served last, and how many BUSY cycles have elapsed.
  int own  = -1;
  int last = 1;
  int age  = 0;
  bit done0, done1;

  always @(negedge clk) begin : cmp
    logic [1:0]    e_grant, e_ack, e_err;
    logic          e_ssel, e_swe, osel;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_sdata, e_d0, e_d1;
    if (run_model) begin
      e_grant = 2'b00; e_ack = 2'b00; e_err = 2'b00;
      e_ssel = 1'b0; e_swe = 1'b0; e_saddr = '0; e_sdata = '0; e_d0 = '0; e_d1 = '0;
      osel = (own == 1) ? m1_select_i : m0_select_i;
      if (own == 0 || own == 1) begin
        e_grant    = (own == 0) ? 2'b01 : 2'b10;
        e_ssel     = osel;
        e_swe      = (own == 0) ? m0_we_i   : m1_we_i;
        e_saddr    = (own == 0) ? m0_addr_i : m1_addr_i;
        e_sdata    = (own == 0) ? m0_data_i : m1_data_i;
        e_ack[own] = s_ack_i;
        e_err[own] = (age == TMO - 1) && !s_ack_i && osel;
        if (own == 0) e_d0 = s_data_i; else e_d1 = s_data_i;
      end
      chk("grant", grant_o, e_grant);
      chk("s_select", s_select_o, e_ssel);
      chk("s_we", s_we_o, e_swe);
      chk("s_addr", s_addr_o, e_saddr);
      chk("s_data", s_data_o, e_sdata);
      chk("m0_ack", m0_ack_o, e_ack[0]);
      chk("m1_ack", m1_ack_o, e_ack[1]);
      chk("m0_err", m0_err_o, e_err[0]);
      chk("m1_err", m1_err_o, e_err[1]);
      chk("m0_data", m0_data_o, e_d0);
      chk("m1_data", m1_data_o, e_d1);

      if (rst) begin
        own = -1; last = 1; age = 0;
      end else if (own == -1) begin
        if (m0_select_i && m1_select_i) own = (last == 0) ? 1 : 0;
        else if (m0_select_i)           own = 0;
        else if (m1_select_i)           own = 1;
        if (own >= 0) begin last = own; age = 0; end
      end else if (own == 2) begin
        own = -1;
      end else if (s_ack_i || !osel || age == TMO - 1) begin
        own = 2;
      end else begin
        age++;
      end
    end
    done0 = m0_ack_o | m0_err_o;
    done1 = m1_ack_o | m1_err_o;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic quiet();
    m0_select_i = 0; m1_select_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
    s_ack_i = 0; s_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    logic [1:0] seen [4];
    int n;
    int ack_pct;
    rst = 1; quiet();
    tick(); run_model = 1;
    tick(); tick();

    // Reset values
    at_neg();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_s_select", s_select_o, 1'b0);
    chk("rst_s_addr", s_addr_o, '0);
    chk("rst_m0_ack", m0_ack_o, 1'b0);
    tick(); rst = 0;

    // m0 read, flash acks on the 5th BUSY cycle
    m0_select_i = 1; m0_addr_i = 32'h0000_0010;
    at_neg(); chk("t1_idle_grant", grant_o, 2'b00);
    tick();
    at_neg();
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_s_select", s_select_o, 1'b1);
    chk("t1_s_addr", s_addr_o, 64'h10);
    tick(); tick(); tick();
    tick(); s_ack_i = 1; s_data_i = 32'h0000_ABCD;
    at_neg();
    chk("t1_m0_ack", m0_ack_o, 1'b1);
    chk("t1_m0_data", m0_data_o, 64'hABCD);
    chk("t1_m1_ack", m1_ack_o, 1'b0);
    tick(); quiet();
    at_neg();
    chk("t1_release_grant", grant_o, 2'b00);
    tick();

    // Both held with an always-acking flash: grants alternate starting at m0
    do_reset();
    m0_select_i = 1; m1_select_i = 1; s_ack_i = 1;
    n = 0;
    for (int i = 0; i < 4; i++) seen[i] = 2'b00;
    for (int c = 0; c < 16; c++) begin
      at_neg();
      if (grant_o != 2'b00 && n < 4) begin seen[n] = grant_o; n++; end
      tick();
    end
    for (int i = 0; i < 4; i++) chk("t2_rr_order", seen[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    quiet(); tick();

    // m1 write while m0 waits
    do_reset();
    m1_select_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0200; m1_data_i = 32'h1234;
    tick();
    m0_select_i = 1; m0_addr_i = 32'h40; m0_data_i = 32'hDEAD;
    at_neg();
    chk("t3_s_we", s_we_o, 1'b1);
    chk("t3_s_data", s_data_o, 64'h1234);
    chk("t3_s_addr", s_addr_o, 64'h200);
    chk("t3_grant", grant_o, 2'b10);
    tick(); s_ack_i = 1; s_data_i = 32'h5555;
    at_neg();
    chk("t3_m1_ack", m1_ack_o, 1'b1);
    chk("t3_m0_ack", m0_ack_o, 1'b0);
    chk("t3_m0_data", m0_data_o, 64'h0);
    tick(); s_ack_i = 0; m1_select_i = 0; m1_we_i = 0;
    at_neg();
    chk("t3_rel_s_we", s_we_o, 1'b0);
    chk("t3_rel_s_data", s_data_o, 64'h0);
    tick();
    at_neg(); chk("t3_idle_grant", grant_o, 2'b00);
    tick();
    m1_select_i = 1; m1_addr_i = 32'h300;
    at_neg();
    chk("t3_m0_grant", grant_o, 2'b01);
    chk("t3_m0_addr", s_addr_o, 64'h40);

    // m0 times out on its 8th BUSY cycle, then pending m1 is granted
    for (int c = 2; c <= TMO; c++) begin
      tick(); at_neg();
      if (c == TMO - 1) chk("t4_err_early", m0_err_o, 1'b0);
      if (c == TMO) begin
        chk("t4_m0_err", m0_err_o, 1'b1);
        chk("t4_m1_err", m1_err_o, 1'b0);
        chk("t4_m0_ack", m0_ack_o, 1'b0);
      end
    end
    tick(); m0_select_i = 0;
    at_neg(); chk("t4_release", grant_o, 2'b00);
    tick(); at_neg(); chk("t4_idle", grant_o, 2'b00);
    tick(); at_neg(); chk("t4_m1_grant", grant_o, 2'b10);

    // Ack coinciding with the timeout cycle
    for (int c = 2; c <= TMO; c++) begin
      tick();
      if (c == TMO) s_ack_i = 1;
    end
    at_neg();
    chk("t5_m1_ack", m1_ack_o, 1'b1);
    chk("t5_m1_err", m1_err_o, 1'b0);
    tick(); quiet(); tick(); tick();

    // Reset mid-BUSY1 followed by a late ack
    m1_select_i = 1; m1_addr_i = 32'h400;
    tick(); tick(); rst = 1;
    at_neg(); chk("t6_busy", grant_o, 2'b10);
    tick(); rst = 0; m1_select_i = 0; s_ack_i = 1;
    at_neg();
    chk("t6_s_select", s_select_o, 1'b0);
    chk("t6_m1_ack", m1_ack_o, 1'b0);
    chk("t6_grant", grant_o, 2'b00);
    chk("t6_s_addr", s_addr_o, 64'h0);
    tick(); s_ack_i = 0;

    // Randomized traffic
    ack_pct = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (cyc % 400 == 0) begin
        case ((cyc / 400) % 4)
          0: ack_pct = 0;
          1: ack_pct = 10;
          2: ack_pct = 35;
          default: ack_pct = 80;
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      if (m0_select_i) begin
        if (done0 || $urandom_range(0, 59) == 0) m0_select_i = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        m0_select_i = 1; m0_addr_i = $urandom; m0_data_i = $urandom;
        m0_we_i = 1'($urandom_range(0, 1));
      end
      if (m1_select_i) begin
        if (done1 || $urandom_range(0, 59) == 0) m1_select_i = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        m1_select_i = 1; m1_addr_i = $urandom; m1_data_i = $urandom;
        m1_we_i = 1'($urandom_range(0, 1));
      end
      s_ack_i  = ($urandom_range(0, 99) < ack_pct);
      s_data_i = $urandom;
    end
    rst = 0; quiet();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
